// File: rtl/pdp8l_memcyc_init.sv
// pdp8l_memcyc_init: CPU-side memory-cycle initiator for the PDP-8/L memory bus.
// The ARM loads mode/field/address/data through register 1. The block then runs
// one data-break style cycle (read-restore, write or increment) against the
// extended-memory responder and reports the read and written-back words.
`timescale 1ns/1ps

module pdp8l_memcyc_init #(
    parameter logic [7:0]  TMODEF  = 8'd200,
    parameter logic [11:0] VERSION = 12'h001
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic        armwrite,
    input  logic [1:0]  armraddr,
    input  logic [1:0]  armwaddr,
    input  logic [31:0] armwdata,
    output logic [31:0] armrdata,
    output logic        memstart,
    output logic [11:0] memaddr,
    output logic [11:0] memwdat,
    output logic [2:0]  brkfld,
    output logic        _bf_enab,
    input  logic [11:0] memrdat,
    input  logic        _mrdone,
    input  logic        _mwdone
);

    // Bus handshake: memstart is a single-clock pulse that opens a cycle while
    // _bf_enab is low and brkfld/memaddr are stable. The responder answers with
    // an active-low _mrdone pulse (memrdat valid at its falling edge), then later
    // samples memwdat and answers with an active-low _mwdone pulse. A strobe is
    // honoured on its 1->0 edge; the cycle only moves on once the strobe is high
    // again, so one long pulse can never be counted twice.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WRD   = 3'd2,
        S_WRDH  = 3'd3,
        S_WWR   = 3'd4,
        S_WWRH  = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  mode;
    logic [2:0]  field;
    logic [11:0] addr;
    logic [11:0] data;
    logic        tmo;
    logic        done;
    logic        zero;
    logic [11:0] rdat;
    logic [11:0] wdat;
    logic [7:0]  tlim;
    logic [7:0]  tcnt;
    logic        mrdone_q;
    logic        mwdone_q;

    logic        busy;
    logic        mrd_fall;
    logic        mwd_fall;
    logic        waiting;
    logic        tmo_hit;
    logic        do_start;
    logic        do_capture;
    logic        do_done;
    logic        do_tmo;
    logic [11:0] inc_val;
    logic [11:0] new_wdat;
    logic        new_zero;
    logic        unused_bits;

    // Bits 31 and 28:27 of a register-1 write carry no meaning.
    assign unused_bits = &{1'b0, armwdata[31], armwdata[28:27]};

    assign busy     = (state != S_IDLE);
    assign mrd_fall = mrdone_q & ~_mrdone;
    assign mwd_fall = mwdone_q & ~_mwdone;
    assign waiting  = (state == S_WRD) || (state == S_WRDH) ||
                      (state == S_WWR) || (state == S_WWRH);
    // Fires on the edge where the wait counter would reach tlim; tlim = 0 never fires.
    assign tmo_hit  = waiting && (tlim != 8'd0) && (tcnt == tlim - 8'd1);

    // Write-back word for the current mode (mode 3 behaves as read-restore).
    always_comb begin
        inc_val  = memrdat + 12'd1;
        new_wdat = memrdat;
        new_zero = 1'b0;
        case (mode)
            2'd1:    new_wdat = data;
            2'd2: begin
                new_wdat = inc_val;
                new_zero = (inc_val == 12'd0);
            end
            default: new_wdat = memrdat;
        endcase
    end

    // State register.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and per-edge action strobes; strobe progress beats timeout.
    always_comb begin
        state_next = state;
        do_start   = 1'b0;
        do_capture = 1'b0;
        do_done    = 1'b0;
        do_tmo     = 1'b0;
        case (state)
            S_IDLE: begin
                if (armwrite && (armwaddr == 2'd1)) begin
                    state_next = S_START;
                    do_start   = 1'b1;
                end
            end
            S_START: state_next = S_WRD;
            S_WRD: begin
                if (mrd_fall) begin
                    state_next = S_WRDH;
                    do_capture = 1'b1;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                    do_tmo     = 1'b1;
                end
            end
            S_WRDH: begin
                if (_mrdone) begin
                    state_next = S_WWR;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                    do_tmo     = 1'b1;
                end
            end
            S_WWR: begin
                if (mwd_fall) begin
                    state_next = S_WWRH;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                    do_tmo     = 1'b1;
                end
            end
            S_WWRH: begin
                if (_mwdone) begin
                    state_next = S_IDLE;
                    do_done    = 1'b1;
                end else if (tmo_hit) begin
                    state_next = S_IDLE;
                    do_tmo     = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath, bus outputs, status flags, wait counter and strobe edge registers.
    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            memstart <= 1'b0;
            memaddr  <= 12'd0;
            memwdat  <= 12'd0;
            brkfld   <= 3'd0;
            _bf_enab <= 1'b1;
            mode     <= 2'd0;
            field    <= 3'd0;
            addr     <= 12'd0;
            data     <= 12'd0;
            tmo      <= 1'b0;
            done     <= 1'b0;
            zero     <= 1'b0;
            rdat     <= 12'd0;
            wdat     <= 12'd0;
            tlim     <= TMODEF;
            tcnt     <= 8'd0;
            mrdone_q <= 1'b1;
            mwdone_q <= 1'b1;
        end else begin
            mrdone_q <= _mrdone;
            mwdone_q <= _mwdone;
            memstart <= do_start;

            // Status clear comes first so a same-edge completion still sets done.
            if (armwrite && (armwaddr == 2'd2)) begin
                tmo  <= 1'b0;
                done <= 1'b0;
                zero <= 1'b0;
            end
            if (armwrite && (armwaddr == 2'd3)) begin
                tlim <= armwdata[7:0];
            end

            if (do_start) begin
                mode     <= armwdata[30:29];
                field    <= armwdata[26:24];
                addr     <= armwdata[23:12];
                data     <= armwdata[11:0];
                memaddr  <= armwdata[23:12];
                brkfld   <= armwdata[26:24];
                _bf_enab <= 1'b0;
                tmo      <= 1'b0;
                done     <= 1'b0;
                zero     <= 1'b0;
            end
            // Write-back data is settled right after the read strobe, long
            // before the responder samples it for the restore half.
            if (do_capture) begin
                rdat    <= memrdat;
                wdat    <= new_wdat;
                memwdat <= new_wdat;
                zero    <= new_zero;
            end
            if (do_done) begin
                done     <= 1'b1;
                _bf_enab <= 1'b1;
                brkfld   <= 3'd0;
            end
            if (do_tmo) begin
                tmo      <= 1'b1;
                _bf_enab <= 1'b1;
                brkfld   <= 3'd0;
            end

            if (state_next != state) begin
                tcnt <= 8'd0;
            end else if (waiting) begin
                tcnt <= tcnt + 8'd1;
            end
        end
    end

    // ARM register read mux.
    always_comb begin
        armrdata = 32'd0;
        case (armraddr)
            2'd0:    armrdata = {16'h4D49, 4'h1, VERSION};
            2'd1:    armrdata = {busy, mode, 2'b00, field, addr, data};
            2'd2:    armrdata = {tmo, done, zero, 5'b00000, rdat, wdat};
            default: armrdata = {24'd0, tlim};
        endcase
    end

endmodule

// File: tb/tb_pdp8l_memcyc_init.sv
// tb_pdp8l_memcyc_init: bench for the PDP-8/L memory-cycle initiator with a
// behavioural extended-memory responder and a backdoor-accessible memory.
`timescale 1ns/1ps

module tb_pdp8l_memcyc_init;

    // Clock and reset
    logic        clk;
    logic        rst_n;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic        armwrite;
    logic [1:0]  armraddr;
    logic [1:0]  armwaddr;
    logic [31:0] armwdata;
    logic [31:0] armrdata;
    logic        memstart;
    logic [11:0] memaddr;
    logic [11:0] memwdat;
    logic [2:0]  brkfld;
    logic        bf_enab;
    logic [11:0] memrdat;
    logic        resp_mrdone;
    logic        resp_mwdone;
    logic        spur_mrdone;
    logic        spur_mwdone;
    logic        mrdone_w;
    logic        mwdone_w;

    assign mrdone_w = resp_mrdone & spur_mrdone;
    assign mwdone_w = resp_mwdone & spur_mwdone;

    pdp8l_memcyc_init dut (
        .CLOCK    (clk),
        .RESET    (rst_n),
        .armwrite (armwrite),
        .armraddr (armraddr),
        .armwaddr (armwaddr),
        .armwdata (armwdata),
        .armrdata (armrdata),
        .memstart (memstart),
        .memaddr  (memaddr),
        .memwdat  (memwdat),
        .brkfld   (brkfld),
        ._bf_enab (bf_enab),
        .memrdat  (memrdat),
        ._mrdone  (mrdone_w),
        ._mwdone  (mwdone_w)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboard: {rdat, wdat, zero, memory after}
    logic [36:0] exp_q[$];

    // Behavioural responder with backdoor memory
    logic [11:0] mem [0:32767];
    logic        resp_en   = 1'b0;
    logic        resp_busy = 1'b0;
    int          resp_phase = 0;
    logic [14:0] r_idx;
    int          ms_count = 0;

    // Counts memstart high clocks, sampled 1 ns after each rising edge.
    always begin
        @(posedge clk); #1;
        if (memstart) ms_count++;
    end

    // Responder: read strobe 10 clocks after memstart, write strobe 60 clocks later.
    always begin
        @(posedge clk); #1;
        if (resp_en && memstart) begin
            resp_busy  = 1'b1;
            resp_phase = 1;
            r_idx      = {brkfld, memaddr};
            repeat (10) @(posedge clk);
            #1;
            memrdat     = mem[r_idx];
            resp_mrdone = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            resp_mrdone = 1'b1;
            resp_phase  = 2;
            repeat (60) @(posedge clk);
            #1;
            mem[r_idx]  = memwdat;
            resp_mwdone = 1'b0;
            resp_phase  = 3;
            repeat (5) @(posedge clk);
            #1;
            resp_mwdone = 1'b1;
            resp_phase  = 0;
            resp_busy   = 1'b0;
        end
    end

    // Driver tasks: the main thread acts 2 ns after each rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic arm_write(input logic [1:0] a, input logic [31:0] d);
        armwaddr = a;
        armwdata = d;
        armwrite = 1'b1;
        step();
        armwrite = 1'b0;
    endtask

    task automatic read_reg(input logic [1:0] a, output logic [31:0] d);
        armraddr = a;
        #1;
        d = armrdata;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        logic [31:0] d;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            read_reg(2'd1, d);
            if (!d[31]) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_idle"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic wait_resp_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!resp_busy) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        check("resp_idle", {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        logic [31:0] d;
        read_reg(2'd0, d); check({tag, "_reg0"}, d, 32'h4D49_1001);
        read_reg(2'd1, d); check({tag, "_busy"}, {31'd0, d[31]}, 32'd0);
        read_reg(2'd2, d); check({tag, "_reg2"}, d, 32'd0);
        read_reg(2'd3, d); check({tag, "_tlim"}, d, 32'd200);
        check({tag, "_bf_enab"}, {31'd0, bf_enab}, 32'd1);
        check({tag, "_memstart"}, {31'd0, memstart}, 32'd0);
        check({tag, "_brkfld"}, {29'd0, brkfld}, 32'd0);
        check({tag, "_memaddr"}, {20'd0, memaddr}, 32'd0);
        check({tag, "_memwdat"}, {20'd0, memwdat}, 32'd0);
    endtask

    typedef struct packed {
        logic [1:0]  mode;
        logic [2:0]  field;
        logic [11:0] addr;
        logic [11:0] data;
        logic [11:0] init;
        logic [11:0] exp_rdat;
        logic [11:0] exp_wdat;
        logic        exp_zero;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] d;
        logic [36:0] e;
        int          st;
        bit          seen;

        // Vector table: mode, field, addr, data, memory before, rdat, wdat, zero
        vecs[0] = '{2'd1, 3'd3, 12'o1234, 12'o5252, 12'o0000, 12'o0000, 12'o5252, 1'b0};
        vecs[1] = '{2'd2, 3'd1, 12'o0100, 12'o0000, 12'o7777, 12'o7777, 12'o0000, 1'b1};
        vecs[2] = '{2'd2, 3'd1, 12'o0101, 12'o0000, 12'o0017, 12'o0017, 12'o0020, 1'b0};
        vecs[3] = '{2'd0, 3'd5, 12'o0777, 12'o1111, 12'o4321, 12'o4321, 12'o4321, 1'b0};
        vecs[4] = '{2'd3, 3'd7, 12'o7777, 12'o2222, 12'o1357, 12'o1357, 12'o1357, 1'b0};
        vecs[5] = '{2'd1, 3'd0, 12'o0000, 12'o7777, 12'o1111, 12'o1111, 12'o7777, 1'b0};
        vecs[6] = '{2'd2, 3'd2, 12'o0000, 12'o5555, 12'o3777, 12'o3777, 12'o4000, 1'b0};

        for (int i = 0; i < 32768; i++) mem[i] = 12'd0;
        rst_n       = 1'b0;
        armwrite    = 1'b0;
        armraddr    = 2'd0;
        armwaddr    = 2'd0;
        armwdata    = 32'd0;
        memrdat     = 12'd0;
        resp_mrdone = 1'b1;
        resp_mwdone = 1'b1;
        spur_mrdone = 1'b1;
        spur_mwdone = 1'b1;

        // Reset state
        repeat (3) step();
        check_reset("rst");
        rst_n = 1'b1;
        step();
        resp_en = 1'b1;

        // Table-driven cycles
        foreach (vecs[i]) begin
            mem[{vecs[i].field, vecs[i].addr}] = vecs[i].init;
            exp_q.push_back({vecs[i].exp_rdat, vecs[i].exp_wdat, vecs[i].exp_zero, vecs[i].exp_wdat});
            st = ms_count;
            arm_write(2'd1, {1'b0, vecs[i].mode, 2'b00, vecs[i].field, vecs[i].addr, vecs[i].data});
            check("cyc_brkfld", {29'd0, brkfld}, {29'd0, vecs[i].field});
            check("cyc_bf_enab", {31'd0, bf_enab}, 32'd0);
            check("cyc_memaddr", {20'd0, memaddr}, {20'd0, vecs[i].addr});
            read_reg(2'd1, d);
            check("cyc_reg1", d, {1'b1, vecs[i].mode, 2'b00, vecs[i].field, vecs[i].addr, vecs[i].data});
            wait_idle("cyc", 300);
            e = exp_q.pop_front();
            read_reg(2'd2, d);
            check("cyc_rdat", {20'd0, d[23:12]}, {20'd0, e[36:25]});
            check("cyc_wdat", {20'd0, d[11:0]}, {20'd0, e[24:13]});
            check("cyc_zero", {31'd0, d[29]}, {31'd0, e[12]});
            check("cyc_done_tmo", {30'd0, d[31:30]}, 32'd1);
            check("cyc_memwdat", {20'd0, memwdat}, {20'd0, e[24:13]});
            check("cyc_memaddr_hold", {20'd0, memaddr}, {20'd0, vecs[i].addr});
            check("cyc_release", {28'd0, bf_enab, brkfld}, 32'h8);
            check("cyc_pulses", ms_count - st, 1);
            wait_resp_idle();
            check("cyc_mem", {20'd0, mem[{vecs[i].field, vecs[i].addr}]}, {20'd0, e[11:0]});
        end

        // Register-1 write while busy is ignored
        mem[{3'd5, 12'o0001}] = 12'o0123;
        mem[{3'd5, 12'o0200}] = 12'o4321;
        arm_write(2'd1, {1'b0, 2'd0, 2'b00, 3'd5, 12'o0200, 12'o0000});
        repeat (3) step();
        arm_write(2'd1, {1'b0, 2'd1, 2'b00, 3'd5, 12'o0001, 12'o7777});
        read_reg(2'd1, d);
        check("busy_wr_reg1", d, {1'b1, 2'd0, 2'b00, 3'd5, 12'o0200, 12'o0000});
        wait_idle("busy_wr", 300);
        wait_resp_idle();
        check("busy_wr_other", {20'd0, mem[{3'd5, 12'o0001}]}, 32'o0123);
        check("busy_wr_mem", {20'd0, mem[{3'd5, 12'o0200}]}, 32'o4321);

        // Status clear without contention
        arm_write(2'd2, 32'd0);
        read_reg(2'd2, d);
        check("clr_flags", {29'd0, d[31:29]}, 32'd0);

        // Status clear on the completion edge loses to done
        mem[{3'd4, 12'o0040}] = 12'o0007;
        arm_write(2'd1, {1'b0, 2'd2, 2'b00, 3'd4, 12'o0040, 12'o0000});
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (!resp_mwdone) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("race_wstrobe", {31'd0, seen}, 32'd1);
        repeat (5) step();
        arm_write(2'd2, 32'd0);
        read_reg(2'd2, d);
        check("race_done", {29'd0, d[31:29]}, 32'b010);
        check("race_wdat", {20'd0, d[11:0]}, 32'o0010);
        read_reg(2'd1, d);
        check("race_busy", {31'd0, d[31]}, 32'd0);
        wait_resp_idle();

        // Reset in the write-wait state aborts; the late write strobe is ignored
        arm_write(2'd1, {1'b0, 2'd1, 2'b00, 3'd6, 12'o0300, 12'o1212});
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (resp_phase == 2) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        check("rstmid_phase", {31'd0, seen}, 32'd1);
        repeat (10) step();
        rst_n = 1'b0;
        step();
        read_reg(2'd1, d);
        check("rstmid_busy", {31'd0, d[31]}, 32'd0);
        check("rstmid_bf_enab", {31'd0, bf_enab}, 32'd1);
        check("rstmid_out", {memstart, brkfld, memaddr, memwdat}, 32'd0);
        rst_n = 1'b1;
        wait_resp_idle();
        repeat (3) step();
        read_reg(2'd2, d);
        check("rstmid_done", {29'd0, d[31:29]}, 32'd0);
        read_reg(2'd1, d);
        check("rstmid_idle", {31'd0, d[31]}, 32'd0);

        // Spurious strobes in idle
        resp_en = 1'b0;
        spur_mrdone = 1'b0; step();
        spur_mrdone = 1'b1; step();
        spur_mwdone = 1'b0; step();
        spur_mwdone = 1'b1; step();
        read_reg(2'd1, d);
        check("spur_busy", {31'd0, d[31]}, 32'd0);
        read_reg(2'd2, d);
        check("spur_reg2", d, 32'd0);

        // Timeout with no responder, tlim = 20
        arm_write(2'd3, 32'd20);
        read_reg(2'd3, d);
        check("tlim_rd", d, 32'd20);
        arm_write(2'd1, {1'b0, 2'd1, 2'b00, 3'd2, 12'o0500, 12'o0001});
        step();
        repeat (19) step();
        read_reg(2'd2, d);
        check("tmo_early", {31'd0, d[31]}, 32'd0);
        read_reg(2'd1, d);
        check("tmo_early_busy", {31'd0, d[31]}, 32'd1);
        step();
        read_reg(2'd2, d);
        check("tmo_flags", {30'd0, d[31:30]}, 32'b10);
        read_reg(2'd1, d);
        check("tmo_busy", {31'd0, d[31]}, 32'd0);
        check("tmo_release", {28'd0, bf_enab, brkfld}, 32'h8);

        // tlim = 0 disables the timeout
        arm_write(2'd3, 32'd0);
        arm_write(2'd1, {1'b0, 2'd1, 2'b00, 3'd2, 12'o0501, 12'o0002});
        repeat (1000) step();
        read_reg(2'd1, d);
        check("notmo_busy", {31'd0, d[31]}, 32'd1);
        check("notmo_bf_enab", {31'd0, bf_enab}, 32'd0);
        read_reg(2'd2, d);
        check("notmo_tmo", {31'd0, d[31]}, 32'd0);

        // Reset recovers and restores defaults
        rst_n = 1'b0;
        step();
        check_reset("rst2");
        rst_n = 1'b1;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
